// File: rtl/inst_rom.sv
// Word-organised instruction memory: filled through a valid/ready load stream, then serves registered fetches.
// Optional feature macro: INST_ROM_RELOAD_EN adds a 'reload' input that re-enters LOAD from SERVE.
module inst_rom #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        addr_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
`ifdef INST_ROM_RELOAD_EN
  output logic        busy,
  input  logic        reload
`else
  output logic        busy
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LAST_PTR = (DEPTH_LOG2 + 1)'(DEPTH - 1);

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DEPTH_LOG2:0]   ld_ptr;
  logic [DEPTH_LOG2:0]   ld_ptr_next;
  logic                  ld_accept;
  logic                  reload_req;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  fetch_ok;
  logic                  fetch_err;
  logic [DEPTH_LOG2-1:0] index;
  logic [31:0]           mem [0:DEPTH-1];

`ifdef INST_ROM_RELOAD_EN
  assign reload_req = reload;
`else
  assign reload_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      ld_ptr <= '0;
    end else begin
      state  <= state_next;
      ld_ptr <= ld_ptr_next;
    end
  end

  // The pointer stops at the last word: filling the memory ends the load even without ld_last.
  always_comb begin
    state_next  = state;
    ld_ptr_next = ld_ptr;
    ld_ready    = 1'b0;
    busy        = 1'b0;
    ld_accept   = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (ld_valid) begin
          ld_accept   = 1'b1;
          ld_ptr_next = ld_ptr + 1'b1;
          if (ld_last || (ld_ptr == LAST_PTR)) begin
            state_next = SERVE;
          end
        end
      end
      SERVE: begin
        if (reload_req) begin
          state_next  = LOAD;
          ld_ptr_next = '0;
        end
      end
      default: begin
        state_next  = LOAD;
        ld_ptr_next = '0;
      end
    endcase
  end

  always_comb begin
    misaligned   = |addr[1:0];
    out_of_range = (addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    index        = addr[DEPTH_LOG2+1:2];
    fetch_ok     = (state == SERVE) && ce && !reload_req && !misaligned && !out_of_range;
    fetch_err    = (state == SERVE) && ce && !reload_req && (misaligned || out_of_range);
  end

  // Memory has no reset so it can map onto block RAM; reset only blocks a write in its cycle.
  always_ff @(posedge clk) begin
    if (!rst && ld_accept) begin
      mem[ld_ptr[DEPTH_LOG2-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst       <= 32'd0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      inst       <= fetch_ok ? mem[index] : 32'd0;
      inst_valid <= fetch_ok;
      addr_err   <= fetch_err;
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// Directed self-checking bench for inst_rom: a 1024-word instance and a 4-word instance for the full-memory case.
module tb_inst_rom;

  logic        clk = 1'b0;
  logic        rst, ce, ld_valid, ld_last, reload;
  logic [31:0] addr, ld_data;
  logic [31:0] inst;
  logic        inst_valid, addr_err, ld_ready, busy;

  logic        s_rst, s_ce, s_ld_valid, s_ld_last, s_reload;
  logic [31:0] s_addr, s_ld_data;
  logic [31:0] s_inst;
  logic        s_inst_valid, s_addr_err, s_ld_ready, s_busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  inst_rom #(.DEPTH_LOG2(10)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst), .inst_valid(inst_valid), .addr_err(addr_err),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready),
`ifdef INST_ROM_RELOAD_EN
    .busy(busy), .reload(reload)
`else
    .busy(busy)
`endif
  );

  inst_rom #(.DEPTH_LOG2(2)) u_small (
    .clk(clk), .rst(s_rst), .ce(s_ce), .addr(s_addr),
    .inst(s_inst), .inst_valid(s_inst_valid), .addr_err(s_addr_err),
    .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last),
    .ld_ready(s_ld_ready),
`ifdef INST_ROM_RELOAD_EN
    .busy(s_busy), .reload(s_reload)
`else
    .busy(s_busy)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] e_inst, input logic e_valid, input logic e_err);
    check_output({tag, ".inst"}, inst, e_inst);
    check_output({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
    check_output({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, e_err});
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic l, input logic c, input logic [31:0] a);
    ld_valid = v; ld_data = d; ld_last = l; ce = c; addr = a;
    tick();
  endtask

  task automatic apply_small(input logic v, input logic [31:0] d, input logic c, input logic [31:0] a);
    s_ld_valid = v; s_ld_data = d; s_ce = c; s_addr = a;
    tick();
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1; ce = 1'b1; addr = 32'd0; ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0; reload = 1'b0;
    s_rst = 1'b1; s_ce = 1'b0; s_addr = 32'd0; s_ld_valid = 1'b0; s_ld_data = 32'd0; s_ld_last = 1'b0; s_reload = 1'b0;
    tick();
    tick();
    check_output("reset.busy", {31'd0, busy}, 32'd1);
    check_output("reset.ld_ready", {31'd0, ld_ready}, 32'd1);
    check_fetch("reset", 32'd0, 1'b0, 1'b0);

    rst = 1'b0;
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'd0);
    check_fetch("load_fetch", 32'd0, 1'b0, 1'b0);

    // Load three words with idle gaps; the last one coincides with a fetch still sampled in LOAD.
    apply_stimulus(1'b1, 32'h3401_0001, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'd0);
    check_output("gap.busy", {31'd0, busy}, 32'd1);
    apply_stimulus(1'b1, 32'h3402_0002, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 32'hBBBB_BBBB, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b0, 32'hCCCC_CCCC, 1'b0, 1'b0, 32'd0);
    check_output("gap2.ld_ready", {31'd0, ld_ready}, 32'd1);
    apply_stimulus(1'b1, 32'h0022_1820, 1'b1, 1'b1, 32'd0);
    check_output("last.busy", {31'd0, busy}, 32'd0);
    check_output("last.ld_ready", {31'd0, ld_ready}, 32'd0);
    check_fetch("last_same_cycle", 32'd0, 1'b0, 1'b0);

    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0);
    check_fetch("fetch0", 32'h3401_0001, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h4);
    check_fetch("fetch4", 32'h3402_0002, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8);
    check_fetch("fetch8", 32'h0022_1820, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0);
    check_fetch("refetch0", 32'h3401_0001, 1'b1, 1'b0);
    check_output("serve.busy", {31'd0, busy}, 32'd0);

    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'h4);
    check_fetch("ce_low", 32'd0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0002);
    check_fetch("misaligned", 32'd0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_1000);
    check_fetch("out_of_range", 32'd0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h8000_0000);
    check_fetch("high_bit", 32'd0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0FFC);
    check_output("top_word.inst_valid", {31'd0, inst_valid}, 32'd1);
    check_output("top_word.addr_err", {31'd0, addr_err}, 32'd0);

`ifdef INST_ROM_RELOAD_EN
    reload = 1'b1;
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0);
    reload = 1'b0;
    check_output("reload.busy", {31'd0, busy}, 32'd1);
    check_fetch("reload_edge", 32'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    check_output("reload_done.busy", {31'd0, busy}, 32'd0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0);
    check_fetch("reload_fetch0", 32'hDEAD_BEEF, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h4);
    check_fetch("reload_keeps4", 32'h3402_0002, 1'b1, 1'b0);

    reload = 1'b1;
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'h0);
    reload = 1'b0;
    apply_stimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    rst = 1'b1; reload = 1'b1;
    apply_stimulus(1'b1, 32'h9999_9999, 1'b0, 1'b0, 32'h0);
    rst = 1'b0; reload = 1'b0;
    check_output("midload_rst.busy", {31'd0, busy}, 32'd1);
    apply_stimulus(1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0);
    check_fetch("midload_rst_fetch0", 32'h2222_2222, 1'b1, 1'b0);
`endif

    // Small instance: an aborted load, then a full load without ld_last.
    s_rst = 1'b0;
    apply_small(1'b1, 32'h0000_0077, 1'b0, 32'h0);
    s_rst = 1'b1;
    apply_small(1'b1, 32'h0000_0099, 1'b0, 32'h0);
    s_rst = 1'b0;
    check_output("small_rst.busy", {31'd0, s_busy}, 32'd1);
    apply_small(1'b1, 32'hA000_0000, 1'b0, 32'h0);
    apply_small(1'b1, 32'hA000_0001, 1'b0, 32'h0);
    apply_small(1'b1, 32'hA000_0002, 1'b0, 32'h0);
    check_output("small_3words.busy", {31'd0, s_busy}, 32'd1);
    apply_small(1'b1, 32'hA000_0003, 1'b0, 32'h0);
    check_output("full.busy", {31'd0, s_busy}, 32'd0);
    check_output("full.ld_ready", {31'd0, s_ld_ready}, 32'd0);
    apply_small(1'b1, 32'h5555_5555, 1'b1, 32'h0);
    check_output("full.fetch0", s_inst, 32'hA000_0000);
    apply_small(1'b1, 32'h5555_5555, 1'b1, 32'h0);
    check_output("full.no_wrap", s_inst, 32'hA000_0000);
    apply_small(1'b0, 32'd0, 1'b1, 32'hC);
    check_output("full.fetchC", s_inst, 32'hA000_0003);
    check_output("full.fetchC_valid", {31'd0, s_inst_valid}, 32'd1);
    apply_small(1'b0, 32'd0, 1'b1, 32'h10);
    check_output("small_oor.addr_err", {31'd0, s_addr_err}, 32'd1);
    check_output("small_oor.inst", s_inst, 32'd0);

    $display("[TB] done");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_rom.md
# inst_rom

Word-organised instruction memory that answers the fetch stage's `ce`/`pc` requests with one registered instruction per cycle. It sits directly after the PC register in the IF stage. It is filled after reset through a valid/ready load stream before it starts serving fetches. Serving is the counterpart of the PC register: it consumes `ce` and the byte address, and returns `inst` to IF/ID.

## Interface

Parameters:
- `DEPTH_LOG2`, default 10 — log2 of the word count; 1024 words × 32 bit.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `ce`  in  1  — fetch enable from the PC register.
- `addr`  in  32  — fetch byte address (`pc`).
- `inst`  out  32  — fetched instruction; 0 (NOP) when not valid.
- `inst_valid`  out  1  — `inst` holds a real memory word.
- `addr_err`  out  1  — fetch address was misaligned or out of range.
- `ld_valid`  in  1  — load word offered.
- `ld_data`  in  32  — load word.
- `ld_last`  in  1  — offered word is the final one of the image.
- `ld_ready`  out  1  — load word accepted this cycle if `ld_valid`.
- `busy`  out  1  — block is in LOAD; fetches are not served.
- `reload`  in  1  — only present with `INST_ROM_RELOAD_EN`; single-cycle request to re-enter LOAD.

## Operation

- FSM has two states, LOAD and SERVE. Reset enters LOAD, clears `ld_ptr` (width `DEPTH_LOG2`+1) to 0, and clears `inst`, `inst_valid` and `addr_err` to 0. Memory contents are not cleared.
- LOAD behaviour:
  - `ld_ready` = `busy` = 1.
  - On `ld_valid && ld_ready`, write `mem[ld_ptr] <= ld_data` and increment `ld_ptr`.
  - Go to SERVE after accepting a word with `ld_last`=1, or after accepting the word at `ld_ptr` = 2^DEPTH_LOG2−1, whether or not `ld_last` is set. The memory is full at that point; it never wraps.
- SERVE behaviour:
  - `ld_ready` = `busy` = 0. `ld_valid` is ignored and memory is not written.
- Fetch decode, evaluated each cycle in SERVE:
  - Misaligned: `addr[1:0]` ≠ 0.
  - Out of range: `addr[31:DEPTH_LOG2+2]` ≠ 0.
  - Index: `addr[DEPTH_LOG2+1:2]`.
- Fetch response, registered each cycle:
  - LOAD, or `ce`=0: `inst`=0, `inst_valid`=0, `addr_err`=0.
  - SERVE, `ce`=1, address good: `inst`=mem[index], `inst_valid`=1, `addr_err`=0.
  - SERVE, `ce`=1, misaligned or out of range: `inst`=0, `inst_valid`=0, `addr_err`=1.
- Reset mid-load returns to LOAD with `ld_ptr`=0. Words already written remain in memory but will be overwritten by the new image.

## Timing

- Fetch latency is 1 cycle: a request sampled at edge N appears on `inst` / `inst_valid` / `addr_err` after edge N, and stays stable until edge N+1.
- `ld_ready` and `busy` are decoded from the registered state only, with no combinational path from `ld_valid`.
- Last load word accepted at edge N: state is SERVE after edge N. A fetch sampled at edge N+1 of the word written at edge N returns the new data (write-before-read across edges).
- A fetch in the same cycle as the final load word is sampled while still in LOAD and returns 0 / not valid.
- `rst` has priority over every other input, including `reload`.

## Configuration

- `INST_ROM_RELOAD_EN` defined:
  - The `reload` port exists.
  - `reload`=1 in SERVE: at the next edge the state becomes LOAD and `ld_ptr` becomes 0; that edge's fetch response is 0 / not valid.
  - `reload` in LOAD has no effect.
- `INST_ROM_RELOAD_EN` undefined:
  - No `reload` port.
  - SERVE is terminal until `rst`.

## Test plan

- Reset then fetch:
  - Stimulus: `rst`=1 for 2 cycles, then `ce`=1, `addr`=0.
  - Response: `busy`=1, `ld_ready`=1, `inst`=0, `inst_valid`=0, `addr_err`=0.
- Load and fetch:
  - Stimulus: load 0x34010001, 0x34020002, 0x00221820 with `ld_last` on the third word. Then fetch addresses 0x0, 0x4, 0x8 on consecutive cycles.
  - Response: each word appears 1 cycle after its request with `inst_valid`=1. `busy`=0 from the cycle after the third word is accepted.
- Back-pressure and gaps:
  - Stimulus: drive `ld_valid` with idle cycles between words.
  - Response: only cycles with `ld_valid`=1 write and advance `ld_ptr`. Read-back has no holes and no duplicates.
- Bad addresses:
  - Stimulus: fetch 0x00000002, then 0x00001000 (with `DEPTH_LOG2`=10).
  - Response: both return `inst`=0, `inst_valid`=0, `addr_err`=1.
- Full memory:
  - Stimulus: with `DEPTH_LOG2`=2, load 4 words and never assert `ld_last`.
  - Response: SERVE after the 4th word, `ld_ready`=0, and a 5th offered word is ignored (mem[0] unchanged).
- Reload, with `INST_ROM_RELOAD_EN`:
  - Stimulus: in SERVE, pulse `reload`, load 0xDEADBEEF with `ld_last`, then fetch 0x0.
  - Response: `inst`=0xDEADBEEF. A mid-load `rst` instead restarts the load at `ld_ptr`=0.
